solo_squash_wb_ctrl: RTL and testbench

- Wishbone slave control/status block directly upstream of the solo_squash game core in the Caravel user area.
- Bridges the management SoC Wishbone bus to the game: soft reset, button override, a frame counter and a frame interrupt.
- Lets firmware drive and observe the game without the physical pads.
- Pad button inputs pass through it (synchronised) to the game core.

---
 rtl/solo_squash_wb_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_solo_squash_wb_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solo_squash_wb_ctrl.sv
// Wishbone control/status slave in front of the solo_squash game core.
// Provides soft reset, button override, frame counting and a frame interrupt.
module solo_squash_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
    parameter int          FRAME_CNT_W      = 16,
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  pad_btn_i,
    input  logic        game_vsync_i,
    output logic        game_rst_o,
    output logic [3:0]  game_btn_o,
    output logic        irq_o
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_IRQ     = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    // Byte-lane merge: lanes with sel set take the new byte, others keep the old one.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic                   hit_s;
    logic                   accept_s;
    logic                   wr_s;
    logic [1:0]             reg_idx_s;
    logic                   w1c_s;
    logic                   frame_edge_s;
    logic [31:0]            ctrl_word_s;
    logic [31:0]            ctrl_next_s;
    logic [31:0]            status_word_s;
    logic [31:0]            rdata_s;
    logic                   unused_bits_s;

    logic                   ack_r;
    logic [31:0]            dat_r;
    logic                   soft_reset_r;
    logic                   override_en_r;
    logic [3:0]             ovr_btn_r;
    logic                   irq_en_r;
    logic [31:0]            scratch_r;
    logic                   frame_pending_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;
    logic                   vs_s1_r;
    logic                   vs_s2_r;
    logic                   vs_prev_r;
    logic [3:0]             pad_s1_r;
    logic [3:0]             pad_s2_r;
    logic [3:0]             game_btn_r;
    logic                   irq_r;
    logic                   game_rst_r;

    // Address decode; a transfer is accepted only while ack is low, giving one-cycle ack pulses.
    always_comb begin
        hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        accept_s  = hit_s & ~ack_r;
        wr_s      = accept_s & wbs_we_i;
        reg_idx_s = wbs_adr_i[3:2];
        w1c_s     = wr_s & (reg_idx_s == REG_IRQ) & wbs_sel_i[0] & wbs_dat_i[0];
    end

    // Register views and read mux.
    always_comb begin
        ctrl_word_s   = {23'd0, irq_en_r, 2'b00, ovr_btn_r, override_en_r, soft_reset_r};
        ctrl_next_s   = merge_lanes(ctrl_word_s, wbs_dat_i, wbs_sel_i);
        status_word_s = 32'd0;
        status_word_s[FRAME_CNT_W-1:0] = frame_cnt_r;
        status_word_s[31] = vs_s2_r;
        case (reg_idx_s)
            REG_CTRL:    rdata_s = ctrl_word_s;
            REG_STATUS:  rdata_s = status_word_s;
            REG_IRQ:     rdata_s = {31'd0, frame_pending_r};
            REG_SCRATCH: rdata_s = scratch_r;
            default:     rdata_s = 32'd0;
        endcase
    end

    // Frame edge detection on the synchronised vsync, polarity chosen at build time.
    always_comb begin
        if (VSYNC_ACTIVE_LOW) begin
            frame_edge_s = vs_prev_r & ~vs_s2_r;
        end else begin
            frame_edge_s = ~vs_prev_r & vs_s2_r;
        end
    end

    // Bus response: ack and read data are registered; data is zero outside the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else if (accept_s) begin
            ack_r <= 1'b1;
            dat_r <= wbs_we_i ? 32'd0 : rdata_s;
        end else begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end
    end

    // Software-writable registers; writes land on the edge that raises ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            soft_reset_r  <= 1'b0;
            override_en_r <= 1'b0;
            ovr_btn_r     <= 4'd0;
            irq_en_r      <= 1'b0;
            scratch_r     <= 32'd0;
        end else if (wr_s) begin
            case (reg_idx_s)
                REG_CTRL: begin
                    soft_reset_r  <= ctrl_next_s[0];
                    override_en_r <= ctrl_next_s[1];
                    ovr_btn_r     <= ctrl_next_s[5:2];
                    irq_en_r      <= ctrl_next_s[8];
                end
                REG_SCRATCH: scratch_r <= merge_lanes(scratch_r, wbs_dat_i, wbs_sel_i);
                default: ;
            endcase
        end
    end

    // Vsync synchroniser, frame counter and pending flag (a new frame beats a same-cycle clear).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            vs_s1_r         <= 1'b0;
            vs_s2_r         <= 1'b0;
            vs_prev_r       <= 1'b0;
            frame_cnt_r     <= '0;
            frame_pending_r <= 1'b0;
        end else begin
            vs_s1_r   <= game_vsync_i;
            vs_s2_r   <= vs_s1_r;
            vs_prev_r <= vs_s2_r;
            if (soft_reset_r) begin
                frame_cnt_r <= '0;
            end else if (frame_edge_s) begin
                frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            end
            if (frame_edge_s) begin
                frame_pending_r <= 1'b1;
            end else if (w1c_s) begin
                frame_pending_r <= 1'b0;
            end
        end
    end

    // Pad synchroniser and registered game-side outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pad_s1_r   <= 4'd0;
            pad_s2_r   <= 4'd0;
            game_btn_r <= 4'd0;
            irq_r      <= 1'b0;
            game_rst_r <= 1'b1;
        end else begin
            pad_s1_r   <= pad_btn_i;
            pad_s2_r   <= pad_s1_r;
            game_btn_r <= override_en_r ? ovr_btn_r : pad_s2_r;
            irq_r      <= irq_en_r & frame_pending_r;
            game_rst_r <= soft_reset_r;
        end
    end

    assign unused_bits_s = ^{wbs_adr_i[1:0], ctrl_next_s[31:9], ctrl_next_s[7:6]};

    assign wbs_ack_o  = ack_r;
    assign wbs_dat_o  = dat_r;
    assign game_btn_o = game_btn_r;
    assign irq_o      = irq_r;
    assign game_rst_o = game_rst_r;

endmodule

// File: tb/tb_solo_squash_wb_ctrl.sv
// Scoreboard bench for solo_squash_wb_ctrl: bus reads are predicted by a register-level
// model at issue time and compared by an independent ack monitor.
module tb_solo_squash_wb_ctrl;

    localparam int          CNT_W = 10;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_IRQ  = BASE + 32'h8;
    localparam logic [31:0] A_SCR  = BASE + 32'hC;

    logic        clk;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [3:0]  pad;
    logic        vsync;
    logic        game_rst;
    logic [3:0]  game_btn;
    logic        irq;

    solo_squash_wb_ctrl #(
        .BASE_ADDR(BASE), .FRAME_CNT_W(CNT_W), .VSYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .pad_btn_i(pad), .game_vsync_i(vsync),
        .game_rst_o(game_rst), .game_btn_o(game_btn), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] d;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   prev_ack = 1'b0;

    logic [31:0] m_ctrl, m_scratch;
    int unsigned m_count;
    bit          m_pending, m_vs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        case (a[3:2])
            2'd0:    v = m_ctrl;
            2'd1:    v = (32'(m_vs) << 31) | 32'(m_count);
            2'd2:    v = 32'(m_pending);
            default: v = m_scratch;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = lane_mask(s);
        case (a[3:2])
            2'd0: begin
                m_ctrl = ((m_ctrl & ~m) | (d & m)) & 32'h0000_013F;
                if (m_ctrl[0]) m_count = 0;
            end
            2'd2: if (s[0] && d[0]) m_pending = 1'b0;
            2'd3: m_scratch = (m_scratch & ~m) | (d & m);
            default: ;
        endcase
    endtask

    task automatic model_frame();
        if (!m_ctrl[0]) m_count = (m_count + 1) % (1 << CNT_W);
        m_pending = 1'b1;
    endtask

    // Issue one transfer starting just after a rising edge; returns just after the ack edge.
    task automatic wb_issue(input logic [31:0] a, input bit w, input logic [31:0] d,
                            input logic [3:0] s, input string name);
        exp_t e;
        int   n;
        bit   got;
        e.rd = !w;
        e.d = w ? 32'd0 : model_read(a);
        e.name = name;
        sb_q.push_back(e);
        if (w) model_write(a, d, s);
        adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        got = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            n = i;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; wdat = 32'd0; adr = 32'd0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack within 8 cycles", name);
            void'(sb_q.pop_back());
        end else begin
            chk({name, "_latency"}, 32'(n), 32'd1);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                           input logic [3:0] s, input string name);
        wb_issue(a, w, d, s, name);
        @(posedge clk); #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        vsync = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        model_frame();
    endtask

    // Monitor: every ack must be expected, one cycle wide, and carry the predicted read data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack) begin
                chk("ack_pulse", 32'(prev_ack), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with dat 0x%08h, expected none", rdat);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.rd) chk(e.name, rdat, e.d);
                end
            end else begin
                chk("dat_idle", rdat, 32'd0);
            end
            prev_ack = ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        int unsigned n_fast;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0;
        adr = 32'd0; wdat = 32'd0; pad = 4'd0; vsync = 1'b0;
        m_ctrl = 32'd0; m_scratch = 32'd0; m_count = 0; m_pending = 1'b0; m_vs = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_game_rst", 32'(game_rst), 32'd1);
        chk("rst_game_btn", 32'(game_btn), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        mon_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("game_rst_release", 32'(game_rst), 32'd0);

        wb_xfer(A_CTRL, 1'b0, 32'd0, 4'hF, "rd_ctrl_rst");
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_rst");
        wb_xfer(A_IRQ,  1'b0, 32'd0, 4'hF, "rd_irq_rst");
        wb_xfer(A_SCR,  1'b0, 32'd0, 4'hF, "rd_scr_rst");

        vsync = 1'b1; m_vs = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        wb_xfer(A_SCR, 1'b1, 32'hDEAD_BEEF, 4'b0101, "wr_scr");
        wb_xfer(A_SCR, 1'b0, 32'd0, 4'hF, "rd_scr_lanes");
        chk("scr_lanes_model", m_scratch, 32'h00AD_00EF);

        // Access just past the window: must be ignored entirely.
        adr = BASE + 32'h10; cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = 32'hFFFF_FFFF; sel = 4'hF;
        saw = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (ack) saw = 1'b1; end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; wdat = 32'd0; adr = 32'd0;
        chk("miss_no_ack", 32'(saw), 32'd0);
        @(posedge clk); #1;
        wb_xfer(A_SCR, 1'b0, 32'd0, 4'hF, "rd_scr_after_miss");
        wb_xfer(A_CTRL, 1'b0, 32'd0, 4'hF, "rd_ctrl_after_miss");

        pad = 4'b0010;
        repeat (2) begin @(posedge clk); #1; end
        chk("pad_latency_early", 32'(game_btn), 32'd0);
        @(posedge clk); #1;
        chk("pad_latency_3", 32'(game_btn), 32'b0010);
        wb_xfer(A_CTRL, 1'b1, 32'h26, 4'hF, "wr_ctrl_ovr");
        pad = 4'b0110;
        repeat (4) begin @(posedge clk); #1; end
        chk("override_btn", 32'(game_btn), 32'b1001);
        wb_xfer(A_CTRL, 1'b1, 32'h100, 4'hF, "wr_ctrl_irqen");
        repeat (2) begin @(posedge clk); #1; end
        chk("override_off_btn", 32'(game_btn), 32'b0110);

        // First frame: pending sets 3 edges after the vsync drop, irq one edge later.
        vsync = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("irq_before", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_rise", 32'(irq), 32'd1);
        model_frame();
        vsync = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        frame();
        frame();
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_3");
        wb_xfer(A_IRQ, 1'b0, 32'd0, 4'hF, "rd_irq_pending");

        wb_issue(A_IRQ, 1'b1, 32'd1, 4'h1, "w1c");
        chk("irq_hold_at_clear", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_fall", 32'(irq), 32'd0);
        wb_xfer(A_IRQ, 1'b0, 32'd0, 4'hF, "rd_irq_cleared");

        // Clear lands on the same edge as a new frame: the frame wins.
        vsync = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        wb_xfer(A_IRQ, 1'b1, 32'd1, 4'h1, "w1c_collide");
        model_frame();
        vsync = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        wb_xfer(A_IRQ, 1'b0, 32'd0, 4'hF, "rd_irq_collide");
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_4");
        chk("irq_after_collide", 32'(irq), 32'd1);

        n_fast = ((1 << CNT_W) - 1) - m_count;
        for (int i = 0; i < int'(n_fast); i++) begin
            vsync = 1'b0; @(posedge clk); #1;
            vsync = 1'b1; @(posedge clk); #1;
            model_frame();
        end
        repeat (4) begin @(posedge clk); #1; end
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_max");
        frame();
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_wrap");
        frame();
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_after_wrap");

        wb_issue(A_CTRL, 1'b1, 32'h101, 4'hF, "wr_soft_reset");
        chk("soft_rst_before", 32'(game_rst), 32'd0);
        @(posedge clk); #1;
        chk("soft_rst_assert", 32'(game_rst), 32'd1);
        frame();
        frame();
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_held");
        wb_xfer(A_CTRL, 1'b0, 32'd0, 4'hF, "rd_ctrl_soft");
        wb_xfer(A_CTRL, 1'b1, 32'h100, 4'hF, "wr_soft_release");
        @(posedge clk); #1;
        chk("soft_rst_release", 32'(game_rst), 32'd0);
        frame();
        wb_xfer(A_STAT, 1'b0, 32'd0, 4'hF, "rd_stat_resume");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = BASE + (32'($urandom_range(0, 3)) << 2);
            if ($urandom_range(0, 4) == 0) frame();
            wb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), "rnd");
            wb_xfer(a, 1'b0, 32'd0, 4'($urandom_range(0, 15)), "rnd_rd");
        end

        repeat (5) begin @(posedge clk); #1; end
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
